pipe_stage: RTL and testbench
=============================

PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter DATA_W, 32, width of each data channel.
REQ-002 Parameter NUM_DATA, 2, number of data channels (1..4).
REQ-003 Parameter CTRL_W, 3, width of packed control field (reg_wen, dmem_alu, jr in default use).
REQ-004 Parameter REGD_W, 5, destination register index width.
REQ-005 Parameter DEPTH, 1, number of register stages (1..4).
REQ-006 clk  input  1  single clock; all state updates on posedge clk.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 flush  input  1  synchronous kill of all in-flight entries.
REQ-009 in_valid  input  1  upstream entry present.
REQ-010 in_ready  output  1  stage accepts entry this cycle.
REQ-011 in_data  input  NUM_DATA*DATA_W  packed data channels, channel 0 in LSBs.
REQ-012 in_ctrl  input  CTRL_W  control field.
REQ-013 in_regd  input  REGD_W  destination register (rd or rt).
REQ-014 out_valid  output  1  last stage holds a valid entry.
REQ-015 out_ready  input  1  downstream accepts entry.
REQ-016 out_data, out_ctrl, out_regd  output  as inputs  last-stage contents.
REQ-017 occupancy  output  $clog2(DEPTH+2)  count of valid entries held, skid entry included.

Function
REQ-018 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-019 Each stage i SHALL load from stage i-1 (or inputs for i=0) when stage i is empty or stage i advances.
REQ-020 Stage i advances when stage i+1 is empty or advances; the last stage advances on out_ready.
REQ-021 Latency in->out SHALL be exactly DEPTH cycles with no stalls; throughput one entry per cycle.
REQ-022 Bubbles SHALL collapse: an empty stage accepts regardless of downstream stall.
REQ-023 A stage not valid SHALL hold ctrl and regd at 0 (bubble = NOP, reg_wen 0); data fields of empty stages hold previous values.
REQ-024 While held (valid, not advancing), a stage's data/ctrl/regd SHALL be stable.
REQ-025 flush=1: at the next edge all valid bits, ctrl and regd cleared, skid cleared, occupancy 0; in_ready forced 0 that cycle; in_valid entry dropped; out transfer that cycle still counts as delivered.
REQ-026 occupancy SHALL increment on transfer in, decrement on transfer out, unchanged on both, never exceed DEPTH (DEPTH+1 with skid).
REQ-027 out_valid with out_ready=0 SHALL hold until out_ready=1 (no drop, no duplicate).

Reset
REQ-028 rst low asynchronously clears all valid bits, data, ctrl, regd, skid and occupancy to 0; out_valid=0.
REQ-029 rst low mid-stall discards all entries; first post-reset entry behaves as into an empty pipe.
REQ-030 in_ready SHALL be 0 while rst low and 1 in the first cycle after release.

Configuration
REQ-031 Macro PIPE_STAGE_SKID_EN defined: one-entry skid buffer at input; in_ready is a register output (no combinational path out_ready->in_ready); entry arriving as stage 0 stalls is captured in skid and drained first.
REQ-032 Macro undefined: no skid; in_ready = stage 0 empty or stage 0 advancing (combinational from out_ready).
REQ-033 Ordering, latency with no stalls and flush behaviour SHALL be identical in both builds.

Structure
REQ-034 Shared package pipe_pkg holds default width constants (DATA_W, REGD_W, CTRL_W) and control-bit index constants (CTRL_REG_WEN=0, CTRL_DMEM_ALU=1, CTRL_JR=2).
REQ-035 One sub-module pipe_slot: single valid/data/ctrl/regd register with load and clear; instantiated DEPTH times by generate.

Verification
REQ-036 DEPTH=1, out_ready=1, in 0x11111111/0x22222222, ctrl=3'b101, regd=7 -> same on out next cycle, out_valid=1, occupancy 1.
REQ-037 DEPTH=3, stream 5 entries, out_ready=0 cycles 4-6 -> outputs in order, no loss/duplicate, occupancy peaks at 3 (4 with skid).
REQ-038 DEPTH=2, 2 entries held, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy 0, flushed-cycle input absent from output.
REQ-039 rst low while DEPTH=2 full and stalled -> outputs 0 immediately, in_ready=1 cycle after release.
REQ-040 SKID build, out_ready toggled each cycle, in_valid always 1 -> in_ready never combinationally follows out_ready; 10 entries delivered in order.
REQ-041 Bubble: DEPTH=3, single entry then idle -> intermediate empty stages show ctrl=0, regd=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared widths and control-bit positions for the pipe_stage slice.
package pipe_pkg;
  localparam int DATA_W = 32;
  localparam int REGD_W = 5;
  localparam int CTRL_W = 3;

  localparam int CTRL_REG_WEN  = 0;
  localparam int CTRL_DMEM_ALU = 1;
  localparam int CTRL_JR       = 2;
endpackage

// File: rtl/pipe_slot.sv
// One pipeline register: valid, data, ctrl and regd with load and clear.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DW = 2 * DATA_W,
  parameter int CW = CTRL_W,
  parameter int RW = REGD_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load,
  input  logic          d_valid,
  input  logic [DW-1:0] d_data,
  input  logic [CW-1:0] d_ctrl,
  input  logic [RW-1:0] d_regd,
  output logic          q_valid,
  output logic [DW-1:0] q_data,
  output logic [CW-1:0] q_ctrl,
  output logic [RW-1:0] q_regd
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_ctrl  <= '0;
      q_regd  <= '0;
    end else if (clear) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
      q_regd  <= '0;
    end else if (load) begin
      q_valid <= d_valid;
      if (d_valid) begin
        q_data <= d_data;
        q_ctrl <= d_ctrl;
        q_regd <= d_regd;
      end else begin
        // bubble is a NOP; data is left as-is
        q_ctrl <= '0;
        q_regd <= '0;
      end
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// Elastic DEPTH-deep register pipeline with flush and occupancy.
// Define PIPE_STAGE_SKID_EN for a registered in_ready with input skid.
module pipe_stage #(
  parameter int DATA_W   = pipe_pkg::DATA_W,
  parameter int NUM_DATA = 2,
  parameter int CTRL_W   = pipe_pkg::CTRL_W,
  parameter int REGD_W   = pipe_pkg::REGD_W,
  parameter int DEPTH    = 1,
  localparam int DW      = NUM_DATA * DATA_W,
  localparam int OCC_W   = $clog2(DEPTH + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [REGD_W-1:0] in_regd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [REGD_W-1:0] out_regd,
  output logic [OCC_W-1:0]  occupancy
);

  logic [DEPTH-1:0]  v;
  logic [DEPTH-1:0]  adv;
  logic [DEPTH-1:0]  ld;
  logic [DW-1:0]     sd [DEPTH];
  logic [CTRL_W-1:0] sc [DEPTH];
  logic [REGD_W-1:0] sr [DEPTH];

  logic              in_xfer;
  logic              src_v;
  logic [DW-1:0]     src_d;
  logic [CTRL_W-1:0] src_c;
  logic [REGD_W-1:0] src_r;
  logic              sk_cnt;

  // stage i advances if out_ready or any later stage is empty
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      logic a;
      a = out_ready;
      for (int j = i + 1; j < DEPTH; j++)
        a = a | ~v[j];
      adv[i] = a;
    end
  end

  assign ld = ~v | adv;

`ifdef PIPE_STAGE_SKID_EN
  logic              sk_v;
  logic [DW-1:0]     sk_d;
  logic [CTRL_W-1:0] sk_c;
  logic [REGD_W-1:0] sk_r;

  assign in_ready = rst && !sk_v && !flush;
  assign in_xfer  = in_valid && in_ready;
  assign sk_cnt   = sk_v;

  // skid holds the older entry, so it drains first
  assign src_v = sk_v || in_xfer;
  assign src_d = sk_v ? sk_d : in_data;
  assign src_c = sk_v ? sk_c : in_ctrl;
  assign src_r = sk_v ? sk_r : in_regd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sk_v <= 1'b0;
      sk_d <= '0;
      sk_c <= '0;
      sk_r <= '0;
    end else if (flush || (sk_v && ld[0])) begin
      sk_v <= 1'b0;
      sk_c <= '0;
      sk_r <= '0;
    end else if (!sk_v && in_xfer && !ld[0]) begin
      sk_v <= 1'b1;
      sk_d <= in_data;
      sk_c <= in_ctrl;
      sk_r <= in_regd;
    end
  end
`else
  assign in_ready = rst && ld[0] && !flush;
  assign in_xfer  = in_valid && in_ready;
  assign sk_cnt   = 1'b0;

  assign src_v = in_xfer;
  assign src_d = in_data;
  assign src_c = in_ctrl;
  assign src_r = in_regd;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic              pv;
    logic [DW-1:0]     pd;
    logic [CTRL_W-1:0] pc;
    logic [REGD_W-1:0] pr;

    if (i == 0) begin : g_head
      assign pv = src_v;
      assign pd = src_d;
      assign pc = src_c;
      assign pr = src_r;
    end else begin : g_body
      assign pv = v[i-1];
      assign pd = sd[i-1];
      assign pc = sc[i-1];
      assign pr = sr[i-1];
    end

    pipe_slot #(
      .DW(DW),
      .CW(CTRL_W),
      .RW(REGD_W)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .clear  (flush),
      .load   (ld[i]),
      .d_valid(pv),
      .d_data (pd),
      .d_ctrl (pc),
      .d_regd (pr),
      .q_valid(v[i]),
      .q_data (sd[i]),
      .q_ctrl (sc[i]),
      .q_regd (sr[i])
    );
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = sd[DEPTH-1];
  assign out_ctrl  = sc[DEPTH-1];
  assign out_regd  = sr[DEPTH-1];

  always_comb begin
    logic [OCC_W-1:0] cnt;
    cnt = OCC_W'(sk_cnt);
    for (int i = 0; i < DEPTH; i++)
      cnt = cnt + OCC_W'(v[i]);
    occupancy = cnt;
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage at depths 1..3: directed steps plus random
// traffic scored against an in-order queue of accepted entries.
module tb_pipe_stage;
  localparam int DW = 64;

  typedef struct {
    logic [DW-1:0] d;
    logic [2:0]    c;
    logic [4:0]    r;
    int            t;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          iv   [3];
  logic          fl   [3];
  logic          ordy [3];
  logic [DW-1:0] idat [3];
  logic [2:0]    ictl [3];
  logic [4:0]    ireg [3];
  logic          ir   [3];
  logic          ov   [3];
  logic [DW-1:0] odat [3];
  logic [2:0]    octl [3];
  logic [4:0]    oreg [3];
  logic [1:0]    occ0;
  logic [1:0]    occ1;
  logic [2:0]    occ2;

  int   dep [3] = '{1, 2, 3};
  int   checks = 0;
  int   errs = 0;
  int   cyc_n = 0;
  int   peak = 0;
  int   delivered = 0;
  bit   exact = 1'b0;
  ent_t q [$];

  pipe_stage #(.DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .flush(fl[0]),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(idat[0]), .in_ctrl(ictl[0]), .in_regd(ireg[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_data(odat[0]), .out_ctrl(octl[0]), .out_regd(oreg[0]),
    .occupancy(occ0)
  );

  pipe_stage #(.DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .flush(fl[1]),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(idat[1]), .in_ctrl(ictl[1]), .in_regd(ireg[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_data(odat[1]), .out_ctrl(octl[1]), .out_regd(oreg[1]),
    .occupancy(occ1)
  );

  pipe_stage #(.DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .flush(fl[2]),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(idat[2]), .in_ctrl(ictl[2]), .in_regd(ireg[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_data(odat[2]), .out_ctrl(octl[2]), .out_regd(oreg[2]),
    .occupancy(occ2)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int occ_of(input int k);
    case (k)
      0:       return int'(occ0);
      1:       return int'(occ1);
      default: return int'(occ2);
    endcase
  endfunction

  task automatic new_entry(input int k);
    idat[k] = {$urandom, $urandom};
    ictl[k] = 3'($urandom);
    ireg[k] = 5'($urandom);
  endtask

  // one clock of instance k: check outputs, then advance the model
  task automatic step(input int k, output bit acc);
    bit ox;
    int age;
    #1;
    acc = iv[k] && ir[k];
    ox  = ov[k] && ordy[k];
    if (fl[k]) chk("flush_ir", 64'(ir[k]), 64'd0);
    chk("occ", 64'(occ_of(k)), 64'(q.size()));
    if (ov[k]) begin
      chk("ov_q", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        age = cyc_n - q[0].t;
        chk("data", odat[k], q[0].d);
        chk("ctrl", 64'(octl[k]), 64'(q[0].c));
        chk("regd", 64'(oreg[k]), 64'(q[0].r));
        if (exact) chk("lat", 64'(age), 64'(dep[k]));
        else chk("lat_min", 64'(age >= dep[k]), 64'd1);
      end
    end else begin
      chk("bub_ctrl", 64'(octl[k]), 64'd0);
      chk("bub_regd", 64'(oreg[k]), 64'd0);
      if (exact && q.size() > 0)
        chk("ov_due", 64'((cyc_n - q[0].t) < dep[k]), 64'd1);
    end
    @(posedge clk);
    if (ox && q.size() > 0) begin
      void'(q.pop_front());
      delivered++;
    end
    if (fl[k]) q.delete();
    else if (acc) q.push_back('{idat[k], ictl[k], ireg[k], cyc_n});
    cyc_n++;
    if (q.size() > peak) peak = q.size();
    @(negedge clk);
  endtask

  task automatic drain(input int k);
    bit acc;
    iv[k] = 1'b0;
    fl[k] = 1'b0;
    ordy[k] = 1'b1;
    for (int c = 0; c < 20 && q.size() > 0; c++) step(k, acc);
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit r0;
    int sent;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; fl[k] = 1'b0; ordy[k] = 1'b1;
      idat[k] = '0; ictl[k] = '0; ireg[k] = '0;
    end

    // reset state
    #1 rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ov", 64'(ov[k]), 64'd0);
      chk("rst_ir", 64'(ir[k]), 64'd0);
      chk("rst_ctrl", 64'(octl[k]), 64'd0);
      chk("rst_data", odat[k], 64'd0);
      chk("rst_occ", 64'(occ_of(k)), 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) chk("rel_ir", 64'(ir[k]), 64'd1);
    @(negedge clk);

    // depth 1 single transfer
    exact = 1'b1;
    idat[0] = 64'h22222222_11111111;
    ictl[0] = 3'b101;
    ireg[0] = 5'd7;
    iv[0] = 1'b1;
    step(0, acc);
    chk("t36_acc", 64'(acc), 64'd1);
    iv[0] = 1'b0;
    #1;
    chk("t36_ov", 64'(ov[0]), 64'd1);
    chk("t36_data", odat[0], 64'h22222222_11111111);
    chk("t36_ctrl", 64'(octl[0]), 64'd5);
    chk("t36_regd", 64'(oreg[0]), 64'd7);
    chk("t36_occ", 64'(occ0), 64'd1);
    step(0, acc);
    step(0, acc);

    // depth 3 bubble: entry, gap, entry
    idat[2] = 64'hA5A5_0000_5A5A_FFFF;
    ictl[2] = 3'b111;
    ireg[2] = 5'd31;
    iv[2] = 1'b1;
    step(2, acc);
    iv[2] = 1'b0;
    step(2, acc);
    chk("t41_s0_v", 64'(u_d3.g_slot[0].u_slot.q_valid), 64'd0);
    chk("t41_s0_c", 64'(u_d3.g_slot[0].u_slot.q_ctrl), 64'd0);
    chk("t41_s0_r", 64'(u_d3.g_slot[0].u_slot.q_regd), 64'd0);
    chk("t41_s2_c", 64'(u_d3.g_slot[2].u_slot.q_ctrl), 64'd0);
    chk("t41_s2_r", 64'(u_d3.g_slot[2].u_slot.q_regd), 64'd0);
    chk("t41_s1_c", 64'(u_d3.g_slot[1].u_slot.q_ctrl), 64'd7);
    new_entry(2);
    iv[2] = 1'b1;
    step(2, acc);
    iv[2] = 1'b0;
    for (int c = 0; c < 5; c++) step(2, acc);
    chk("t41_empty", 64'(q.size()), 64'd0);

    // depth 3 stream of 5 with out_ready low in cycles 4..6
    exact = 1'b0;
    sent = 0;
    peak = 0;
    delivered = 0;
    new_entry(2);
    for (int c = 1; c <= 14; c++) begin
      ordy[2] = !(c >= 4 && c <= 6);
      iv[2] = (sent < 5);
      step(2, acc);
      if (acc) begin
        sent++;
        new_entry(2);
      end
    end
    drain(2);
`ifdef PIPE_STAGE_SKID_EN
    chk("t37_peak", 64'(peak), 64'd4);
`else
    chk("t37_peak", 64'(peak), 64'd3);
`endif
    chk("t37_count", 64'(delivered), 64'd5);

    // depth 2 held full, then flush with an incoming entry
    ordy[1] = 1'b0;
    sent = 0;
    for (int c = 0; c < 6 && sent < 2; c++) begin
      new_entry(1);
      iv[1] = 1'b1;
      step(1, acc);
      if (acc) sent++;
    end
    chk("t38_fill", 64'(sent), 64'd2);
    new_entry(1);
    iv[1] = 1'b1;
    fl[1] = 1'b1;
    step(1, acc);
    fl[1] = 1'b0;
    iv[1] = 1'b0;
    #1;
    chk("t38_ov", 64'(ov[1]), 64'd0);
    chk("t38_ctrl", 64'(octl[1]), 64'd0);
    chk("t38_occ", 64'(occ1), 64'd0);
    ordy[1] = 1'b1;
    for (int c = 0; c < 4; c++) step(1, acc);

    // depth 2 full and stalled, then asynchronous reset
    ordy[1] = 1'b0;
    sent = 0;
    for (int c = 0; c < 6 && sent < 2; c++) begin
      new_entry(1);
      iv[1] = 1'b1;
      step(1, acc);
      if (acc) sent++;
    end
    iv[1] = 1'b0;
    step(1, acc);
    #2 rst = 1'b0;
    #1;
    chk("t39_ov", 64'(ov[1]), 64'd0);
    chk("t39_data", odat[1], 64'd0);
    chk("t39_ctrl", 64'(octl[1]), 64'd0);
    chk("t39_regd", 64'(oreg[1]), 64'd0);
    chk("t39_occ", 64'(occ1), 64'd0);
    chk("t39_ir", 64'(ir[1]), 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t39_rel_ir", 64'(ir[1]), 64'd1);
    @(negedge clk);
    exact = 1'b1;
    ordy[1] = 1'b1;
    new_entry(1);
    iv[1] = 1'b1;
    step(1, acc);
    chk("t39_acc", 64'(acc), 64'd1);
    iv[1] = 1'b0;
    for (int c = 0; c < 3; c++) step(1, acc);
    exact = 1'b0;

    // depth 2 with out_ready toggling and in_valid held high
    delivered = 0;
    new_entry(1);
    for (int c = 0; c < 60 && delivered < 10; c++) begin
`ifdef PIPE_STAGE_SKID_EN
      ordy[1] = 1'b0;
      #1 r0 = ir[1];
      ordy[1] = 1'b1;
      #1 chk("t40_ir_comb", 64'(ir[1]), 64'(r0));
`endif
      ordy[1] = c[0];
      iv[1] = 1'b1;
      step(1, acc);
      if (acc) new_entry(1);
    end
    chk("t40_count", 64'(delivered >= 10), 64'd1);
    drain(1);

    // depth 3 random traffic with occasional flush
    for (int c = 0; c < 300; c++) begin
      new_entry(2);
      iv[2] = ($urandom_range(3) != 0);
      ordy[2] = ($urandom_range(2) != 0);
      fl[2] = ($urandom_range(39) == 0);
      step(2, acc);
    end
    drain(2);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
